// File: rtl/expand_ones_pkg.sv
// +----------------------------------------------------------------------+
// | expand_ones_pkg : shared thermometer-mask helpers for allocators      |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

package expand_ones_pkg;

  // Widest mask any allocator may request from thermo_mask.
  localparam int unsigned THERMO_MAX_W = 64;

  typedef logic [THERMO_MAX_W-1:0] thermo_mask_t;

  // Single comparator: bit idx of a thermometer mask for the given count.
  function automatic logic thermo_bit(input logic [31:0] count, input logic [31:0] idx);
    return count > idx;
  endfunction

  // Full mask with the low min(count, w) bits set; callers slice to their width.
  function automatic thermo_mask_t thermo_mask(input logic [31:0] count, input logic [31:0] w);
    thermo_mask_t m;
    m = '0;
    for (int unsigned i = 0; i < THERMO_MAX_W; i++) begin
      m[i] = (w > 32'(i)) && thermo_bit(count, 32'(i));
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/expand_ones.sv
// +----------------------------------------------------------------------+
// | expand_ones : count-to-mask (thermometer) expander with a registered  |
// |               copy of the mask for timing-critical consumers          |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module expand_ones
  import expand_ones_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(WIDTH):0]     data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [WIDTH-1:0]           data_out_q,
  output logic                       overflow
);

  logic [31:0]      w_count;
  logic [WIDTH-1:0] w_mask;

  assign w_count = 32'(data_in);

  // Per-bit comparators saturate naturally: any count >= WIDTH lights every bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_mask[i] = thermo_bit(w_count, 32'(i));
  end

  always_comb begin
    data_out = w_mask;
    overflow = w_count > 32'(WIDTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= w_mask;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_expand_ones.sv
// Directed self-checking bench for expand_ones at WIDTH=8 and WIDTH=5.
`timescale 1ns/1ps
`default_nettype none

module tb_expand_ones;

  logic       clk;
  logic       rst;
  logic [3:0] din8;
  logic [7:0] dout8, dq8;
  logic       ovf8;
  logic [2:0] din5;
  logic [4:0] dout5, dq5;
  logic       ovf5;

  int n_checks = 0;
  int n_fail   = 0;

  expand_ones #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .data_in(din8),
    .data_out(dout8), .data_out_q(dq8), .overflow(ovf8)
  );

  expand_ones #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .data_in(din5),
    .data_out(dout5), .data_out_q(dq5), .overflow(ovf5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; din8 = 4'd6; din5 = 3'd4;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dq8 !== 8'h00) begin
      n_fail++; $display("FAIL reset_q8: got %h want %h", dq8, 8'h00);
    end
    n_checks++;
    if (dq5 !== 5'h00) begin
      n_fail++; $display("FAIL reset_q5: got %h want %h", dq5, 5'h00);
    end
    n_checks++;
    if (dout8 !== 8'h3F) begin
      n_fail++; $display("FAIL reset_comb8: got %h want %h", dout8, 8'h3F);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp8 [0:8];
    exp8 = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    for (int n = 0; n <= 8; n++) begin
      din8 = 4'(n);
      #10;
      n_checks++;
      if (dout8 !== exp8[n] || ovf8 !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep8 n=%0d: got %h ovf %b want %h ovf 0", n, dout8, ovf8, exp8[n]);
      end
    end
  endtask

  task automatic test_saturation();
    for (int n = 9; n <= 15; n++) begin
      din8 = 4'(n);
      #10;
      n_checks++;
      if (dout8 !== 8'hFF || ovf8 !== 1'b1) begin
        n_fail++;
        $display("FAIL sat8 n=%0d: got %h ovf %b want ff ovf 1", n, dout8, ovf8);
      end
    end
    din8 = 4'd8;
    #10;
    n_checks++;
    if (dout8 !== 8'hFF || ovf8 !== 1'b0) begin
      n_fail++; $display("FAIL full8: got %h ovf %b want ff ovf 0", dout8, ovf8);
    end
  endtask

  task automatic test_reset_hold();
    @(negedge clk);
    rst = 1'b1; din8 = 4'd5;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dq8 !== 8'h00 || dout8 !== 8'h1F) begin
      n_fail++; $display("FAIL rst_hold: q %h comb %h want q 00 comb 1f", dq8, dout8);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (dq8 !== 8'h1F) begin
      n_fail++; $display("FAIL rst_release: got %h want %h", dq8, 8'h1F);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vin [0:3];
    logic [7:0] vexp [0:3];
    vin  = '{4'd3, 4'd0, 4'd8, 4'd1};
    vexp = '{8'h07, 8'h00, 8'hFF, 8'h01};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      din8 = vin[k];
      @(posedge clk);
      #1;
      n_checks++;
      if (dq8 !== vexp[k]) begin
        n_fail++; $display("FAIL b2b step %0d: got %h want %h", k, dq8, vexp[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    din8 = 4'd8;
    @(posedge clk);
    #1;
    n_checks++;
    if (dq8 !== 8'hFF) begin
      n_fail++; $display("FAIL pre_rst: got %h want ff", dq8);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (dq8 !== 8'h00 || dout8 !== 8'hFF || ovf8 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: q %h comb %h ovf %b want q 00 comb ff ovf 0", dq8, dout8, ovf8);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_width5();
    logic [4:0] exp5 [0:7];
    logic       eovf [0:7];
    exp5 = '{5'h00, 5'h01, 5'h03, 5'h07, 5'h0F, 5'h1F, 5'h1F, 5'h1F};
    eovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int n = 0; n <= 7; n++) begin
      din5 = 3'(n);
      #10;
      n_checks++;
      if (dout5 !== exp5[n] || ovf5 !== eovf[n]) begin
        n_fail++;
        $display("FAIL sweep5 n=%0d: got %h ovf %b want %h ovf %b", n, dout5, ovf5, exp5[n], eovf[n]);
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (dq5 !== 5'h1F) begin
      n_fail++; $display("FAIL q5: got %h want 1f", dq5);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_sweep();
    test_saturation();
    test_reset_hold();
    test_back_to_back();
    test_mid_reset();
    test_width5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
